memory_stage_lsu: RTL

- Parametrised successor of the combinational memory-stage wrapper.
- Sequential load/store unit between the execute/memory pipeline register and the data-memory port.
- Formats stores into byte lanes, then issues a held request/acknowledge transaction to memory.
- Stalls the pipeline until acknowledge or timeout, flags misaligned accesses, and returns sign- or zero-extended load data registered for writeback.

---
 rtl/memory_stage_lsu.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/memory_stage_lsu.sv
// Sequential load/store unit: formats stores into byte lanes, runs a held request/ack
// transaction with timeout, and returns extended load data registered for writeback.
module memory_stage_lsu #(
    parameter int DataWidth     = 32,
    parameter int AddrWidth     = 32,
    parameter int TimeoutCycles = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     valid,
    input  logic                     load,
    input  logic                     store,
    input  logic [2:0]               fun3,
    input  logic [DataWidth-1:0]     operand_b,
    input  logic [AddrWidth-1:0]     alu_out_address,
    input  logic [DataWidth-1:0]     wrap_load_in,
    input  logic                     data_valid,
    output logic                     request,
    output logic                     we_re,
    output logic [AddrWidth-1:0]     addr_out,
    output logic [DataWidth/8-1:0]   mask,
    output logic [DataWidth-1:0]     store_data_out,
    output logic [DataWidth-1:0]     wrap_load_out,
    output logic                     load_valid,
    output logic                     stall,
    output logic                     misaligned,
    output logic                     timeout
);
    localparam int NumBytes = DataWidth / 8;
    localparam int OffW     = $clog2(NumBytes);
    localparam int CntW     = $clog2(TimeoutCycles + 1);

    typedef enum logic {IDLE, REQ} state_e;

    function automatic logic [3:0] size_bytes(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 4'd1;
            3'b001, 3'b101: return 4'd2;
            3'b010:         return 4'd4;
            3'b110:         return (DataWidth == 64) ? 4'd4 : 4'd0;
            3'b011:         return (DataWidth == 64) ? 4'd8 : 4'd0;
            default:        return 4'd0;
        endcase
    endfunction

    function automatic logic [NumBytes-1:0] lane_mask(input logic [OffW-1:0] off,
                                                      input logic [3:0] nbytes);
        logic [NumBytes-1:0] m;
        for (int b = 0; b < NumBytes; b++)
            m[b] = (b >= int'(off)) && (b < int'(off) + int'(nbytes));
        return m;
    endfunction

    // Shift the addressed lanes down, then sign- or zero-fill above the access size.
    function automatic logic [DataWidth-1:0] extend_load(input logic [DataWidth-1:0] word,
                                                         input logic [2:0] f3,
                                                         input logic [OffW-1:0] off);
        logic [DataWidth-1:0] sh;
        logic [DataWidth-1:0] res;
        int                   nbits;
        logic                 fill;
        sh    = word >> {off, 3'b000};
        nbits = 8 << f3[1:0];
        if (nbits > DataWidth) nbits = DataWidth;
        fill = 1'b0;
        for (int i = 0; i < DataWidth; i++)
            if (i == nbits - 1) fill = sh[i] & ~f3[2];
        for (int i = 0; i < DataWidth; i++)
            res[i] = (i < nbits) ? sh[i] : fill;
        return res;
    endfunction

    state_e                 state_q;
    logic [CntW-1:0]        cnt_q;
    logic [2:0]             fun3_q;
    logic [OffW-1:0]        off_q;
    logic                   request_q, we_re_q, load_valid_q, misaligned_q, timeout_q;
    logic [AddrWidth-1:0]   addr_q;
    logic [NumBytes-1:0]    mask_q;
    logic [DataWidth-1:0]   sdata_q, rdata_q;

    logic [OffW-1:0]        offset;
    logic [3:0]             nbytes;
    logic                   access, aligned, start, timeout_hit;
    logic [AddrWidth-1:0]   addr_d;
    logic [NumBytes-1:0]    mask_d;
    logic [DataWidth-1:0]   sdata_d, rdata_d;

    assign offset      = alu_out_address[OffW-1:0];
    assign nbytes      = size_bytes(fun3);
    assign access      = valid && (load || store);
    assign aligned     = (nbytes != 4'd0) && ((4'(offset) & (nbytes - 4'd1)) == 4'd0);
    assign start       = access && aligned;
    assign addr_d      = {alu_out_address[AddrWidth-1:OffW], {OffW{1'b0}}};
    assign mask_d      = lane_mask(offset, nbytes);
    assign sdata_d     = operand_b << {offset, 3'b000};
    assign rdata_d     = extend_load(wrap_load_in, fun3_q, off_q);
    assign timeout_hit = (state_q == REQ) && (cnt_q == CntW'(TimeoutCycles - 1));

    // Gated by rst so every output reads 0 while reset is held.
    assign stall = rst && (((state_q == IDLE) && start) ||
                           ((state_q == REQ) && !data_valid && !timeout_hit));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            fun3_q       <= '0;
            off_q        <= '0;
            request_q    <= 1'b0;
            we_re_q      <= 1'b0;
            load_valid_q <= 1'b0;
            misaligned_q <= 1'b0;
            timeout_q    <= 1'b0;
            addr_q       <= '0;
            mask_q       <= '0;
            sdata_q      <= '0;
            rdata_q      <= '0;
        end else begin
            load_valid_q <= 1'b0;
            misaligned_q <= 1'b0;
            timeout_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (start) begin
                        state_q   <= REQ;
                        request_q <= 1'b1;
                        we_re_q   <= store;
                        addr_q    <= addr_d;
                        mask_q    <= mask_d;
                        sdata_q   <= sdata_d;
                        fun3_q    <= fun3;
                        off_q     <= offset;
                    end else if (access) begin
                        misaligned_q <= 1'b1;
                    end
                end
                REQ: begin
                    if (data_valid) begin
                        state_q   <= IDLE;
                        request_q <= 1'b0;
                        cnt_q     <= '0;
                        if (!we_re_q) begin
                            rdata_q      <= rdata_d;
                            load_valid_q <= 1'b1;
                        end
                    end else if (timeout_hit) begin
                        state_q   <= IDLE;
                        request_q <= 1'b0;
                        cnt_q     <= '0;
                        timeout_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign request        = request_q;
    assign we_re          = we_re_q;
    assign addr_out       = addr_q;
    assign mask           = mask_q;
    assign store_data_out = sdata_q;
    assign wrap_load_out  = rdata_q;
    assign load_valid     = load_valid_q;
    assign misaligned     = misaligned_q;
    assign timeout        = timeout_q;

endmodule
